// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds, fill level and sticky errors.
// Latency: registered read data 1 cycle after pop (FIFO_FWFT_EN: head word visible 1 cycle after first push).
// Backpressure: pushes when full are dropped and set write_error; pops when empty set read_error.
module sync_fifo_prog #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              w_enable,
    input  logic [DATA_W-1:0] w_data,
    input  logic              r_enable,
    output logic [DATA_W-1:0] r_data,
    output logic              r_valid,
    output logic              w_full,
    output logic              r_empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  fill_count,
    output logic              write_error,
    output logic              read_error,
    input  logic              err_clr
);

    localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             af_q, af_d;
    logic             ae_q, ae_d;
    logic             werr_q, werr_d;
    logic             rerr_q, rerr_d;

    logic push_ok;
    logic pop_ok;

    // A push into a full FIFO is only legal when the same-cycle pop frees a slot.
    assign pop_ok  = r_enable && !empty_q;
    assign push_ok = w_enable && (!full_q || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        full_d  = (cnt_d == CNT_W'(DEPTH));
        empty_d = (cnt_d == '0);
        af_d    = (cnt_d >= CNT_W'(AF_THRESH));
        ae_d    = (cnt_d <= CNT_W'(AE_THRESH));
    end

    // A fresh error outranks a same-cycle clear.
    always_comb begin
        werr_d = werr_q;
        rerr_d = rerr_q;
        if (err_clr) begin
            werr_d = 1'b0;
            rerr_d = 1'b0;
        end
        if (w_enable && !push_ok) begin
            werr_d = 1'b1;
        end
        if (r_enable && empty_q) begin
            rerr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            werr_q   <= 1'b0;
            rerr_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            werr_q   <= werr_d;
            rerr_q   <= rerr_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= w_data;
        end
    end

`ifdef FIFO_FWFT_EN
    assign r_data  = empty_q ? '0 : mem_q[rd_ptr_q];
    assign r_valid = !empty_q;
`else
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= pop_ok;
            if (pop_ok) begin
                rdata_q <= mem_q[rd_ptr_q];
            end
        end
    end

    assign r_data  = rdata_q;
    assign r_valid = rvalid_q;
`endif

    assign w_full       = full_q;
    assign r_empty      = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign fill_count   = cnt_q;
    assign write_error  = werr_q;
    assign read_error   = rerr_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed vector table for the 16-deep FIFO plus hand sequences for async reset and a 13-deep wrap check.
module tb_sync_fifo_prog;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 16-deep instance
    logic       a_we = 1'b0, a_re = 1'b0, a_clr = 1'b0;
    logic [7:0] a_wd = '0, a_rd;
    logic       a_rv, a_full, a_empty, a_af, a_ae, a_werr, a_rerr;
    logic [4:0] a_cnt;

    sync_fifo_prog #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .w_enable(a_we), .w_data(a_wd), .r_enable(a_re),
        .r_data(a_rd), .r_valid(a_rv), .w_full(a_full), .r_empty(a_empty),
        .almost_full(a_af), .almost_empty(a_ae), .fill_count(a_cnt),
        .write_error(a_werr), .read_error(a_rerr), .err_clr(a_clr)
    );

    // 13-deep instance
    logic       b_we = 1'b0, b_re = 1'b0, b_clr = 1'b0;
    logic [7:0] b_wd = '0, b_rd;
    logic       b_rv, b_full, b_empty, b_af, b_ae, b_werr, b_rerr;
    logic [3:0] b_cnt;

    sync_fifo_prog #(.DATA_W(8), .DEPTH(13), .AF_THRESH(11), .AE_THRESH(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .w_enable(b_we), .w_data(b_wd), .r_enable(b_re),
        .r_data(b_rd), .r_valid(b_rv), .w_full(b_full), .r_empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae), .fill_count(b_cnt),
        .write_error(b_werr), .read_error(b_rerr), .err_clr(b_clr)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // flags = {full, empty, almost_full, almost_empty, write_error, read_error, r_valid}
    typedef struct {
        logic       we;
        logic [7:0] wd;
        logic       re;
        logic       clr;
        logic [4:0] cnt;
        logic [6:0] flags;
        logic [7:0] rd;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [6:0] fl(input int cnt, input bit werr, input bit rerr, input bit rv);
        return {cnt == 16, cnt == 0, cnt >= 14, cnt <= 2, werr, rerr, rv};
    endfunction

    task automatic add(input bit we, input int wd, input bit re, input bit clr,
                       input int cnt, input logic [6:0] flags, input int rd);
        vec_t v;
        v.we = we; v.wd = 8'(wd); v.re = re; v.clr = clr;
        v.cnt = 5'(cnt); v.flags = flags; v.rd = 8'(rd);
        vecs.push_back(v);
    endtask

    function automatic logic [6:0] a_flags();
        return {a_full, a_empty, a_af, a_ae, a_werr, a_rerr, a_rv};
    endfunction

    logic [7:0] sbq[$];

    initial begin
        // Fill 0x00..0x0F, then overflow
        for (int i = 0; i < 16; i++) add(1, i, 0, 0, i + 1, fl(i + 1, 0, 0, 0), 0);
        add(1, 8'hAA, 0, 0, 16, fl(16, 1, 0, 0), 0);
        // Drain in order, then underflow
        for (int k = 0; k < 16; k++) add(0, 0, 1, 0, 15 - k, fl(15 - k, 1, 0, 1), k);
        add(0, 0, 1, 0, 0, fl(0, 1, 1, 0), 8'h0F);
        // Clear both errors
        add(0, 0, 0, 1, 0, fl(0, 0, 0, 0), 8'h0F);
        // Refill, push+pop at full, drain with 0x55 last
        for (int i = 0; i < 16; i++) add(1, 8'h10 + i, 0, 0, i + 1, fl(i + 1, 0, 0, 0), 8'h0F);
        add(1, 8'h55, 1, 0, 16, fl(16, 0, 0, 1), 8'h10);
        for (int k = 1; k < 16; k++) add(0, 0, 1, 0, 16 - k, fl(16 - k, 0, 0, 1), 8'h10 + k);
        add(0, 0, 1, 0, 0, fl(0, 0, 0, 1), 8'h55);
        // Push+pop at empty: push taken, pop rejected
        add(1, 8'h77, 1, 0, 1, fl(1, 0, 1, 0), 8'h55);
        // Fill to full, overflow together with clear
        for (int i = 0; i < 15; i++) add(1, 8'h78 + i, 0, 0, i + 2, fl(i + 2, 0, 1, 0), 8'h55);
        add(1, 8'hEE, 0, 1, 16, fl(16, 1, 0, 0), 8'h55);
        add(0, 0, 0, 1, 16, fl(16, 0, 0, 0), 8'h55);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_cnt", 32'(a_cnt), 0);
        check("reset_flags", 32'(a_flags()), 32'(fl(0, 0, 0, 0)));
        check("reset_rdata", 32'(a_rd), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            a_we = vecs[i].we; a_wd = vecs[i].wd; a_re = vecs[i].re; a_clr = vecs[i].clr;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_cnt", i), 32'(a_cnt), 32'(vecs[i].cnt));
            check($sformatf("vec%0d_flags", i), 32'(a_flags()), 32'(vecs[i].flags));
            check($sformatf("vec%0d_rdata", i), 32'(a_rd), 32'(vecs[i].rd));
        end
        a_we = 1'b0; a_re = 1'b0; a_clr = 1'b0;

        // Async reset mid-cycle with words stored
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a_we = 1'b1; a_wd = 8'hC0 + 8'(i);
            @(posedge clk);
            #1;
        end
        a_we = 1'b0;
        check("pre_reset_cnt", 32'(a_cnt), 5);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_cnt", 32'(a_cnt), 0);
        check("async_reset_flags", 32'(a_flags()), 32'(fl(0, 0, 0, 0)));
        check("async_reset_rdata", 32'(a_rd), 0);
        @(negedge clk);
        rst_n = 1'b1;
        a_re = 1'b1;
        @(posedge clk);
        #1;
        a_re = 1'b0;
        check("post_reset_pop_flags", 32'(a_flags()), 32'(fl(0, 0, 1, 0)));
        check("post_reset_pop_cnt", 32'(a_cnt), 0);

        // 13-deep: random traffic, queue kept non-empty, pointers wrap
        for (int i = 0; i < 5; i++) begin
            b_we = 1'b1; b_wd = 8'h30 + 8'(i);
            sbq.push_back(b_wd);
            @(posedge clk);
            #1;
        end
        check("b_prefill_cnt", 32'(b_cnt), 5);
        for (int c = 0; c < 40; c++) begin
            logic [7:0] exp_rd;
            bit do_re;
            bit do_we;
            do_re = (sbq.size() > 1) && ($urandom_range(0, 2) != 0);
            do_we = (sbq.size() < 13 || do_re) && ($urandom_range(0, 3) != 0);
            b_re = do_re;
            b_we = do_we;
            b_wd = 8'($urandom);
            exp_rd = 8'h00;
            if (do_re) exp_rd = sbq.pop_front();
            if (do_we) sbq.push_back(b_wd);
            @(posedge clk);
            #1;
            check($sformatf("b_cnt_c%0d", c), 32'(b_cnt), 32'(sbq.size()));
            check($sformatf("b_full_c%0d", c), 32'(b_full), 32'(sbq.size() == 13));
            check($sformatf("b_rvalid_c%0d", c), 32'(b_rv), 32'(do_re));
            if (do_re) check($sformatf("b_rdata_c%0d", c), 32'(b_rd), 32'(exp_rd));
            if (b_cnt > 4'd13) check($sformatf("b_cnt_bound_c%0d", c), 32'(b_cnt), 13);
        end
        b_we = 1'b0; b_re = 1'b0;
        check("b_no_errors", 32'({b_werr, b_rerr}), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
